// File: rtl/control_multiciclo_pkg.sv
// rtl/control_multiciclo_pkg.sv - shared states, opcodes and control encodings for control_multiciclo
package control_multiciclo_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_IMM = 2'd1,
        WB_MEM = 2'd2,
        WB_PC  = 2'd3
    } wb_sel_t;

    // funct7 bit 5 selects SUB only for register-register ops; SRA/SRL for both forms
    function automatic alu_op_t alu_from_funct(input logic [2:0] funct3,
                                               input logic       funct7_b5,
                                               input logic       is_reg);
        case (funct3)
            3'b000:  return (is_reg && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/control_multiciclo_imm_gen.sv
// rtl/control_multiciclo_imm_gen.sv - combinational I/S/B/U/J immediate extraction (module imm_gen)
module imm_gen
    import control_multiciclo_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        case (instr[6:0])
            OPC_STORE:          imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:         imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC: imm = {instr[31:12], 12'b0};
            OPC_JAL:            imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default:            imm = {{20{instr[31]}}, instr[31:20]};
        endcase
    end

endmodule

// File: rtl/control_multiciclo.sv
// rtl/control_multiciclo.sv - multicycle RV32 subset control unit; CONTROL_TRAP_EN enables the TRAP state
module control_multiciclo
    import control_multiciclo_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_req,
    input  logic [31:0] address,
    input  logic        flagZ,
    input  logic        flagError,
    input  logic        mem_ready,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] PC,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [3:0]  SEL_OP,
    output logic [1:0]  Sel_Reg_In,
    output logic        srcA_SEL,
    output logic        srcB_SEL,
    output logic        RD_WE,
    output logic        trap
);

    state_t      state_q, state_d;
    logic [31:0] ir_q, pc_q, target_q, pc_d;
    logic        run_q, pc_load;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] pc_plus4, pc_plus_imm;
    logic        branch_taken, supported, decode_trap, exec_error;
    alu_op_t     alu_op;
    wb_sel_t     wb_sel;
    logic        src_a, src_b;

    assign opcode      = ir_q[6:0];
    assign funct3      = ir_q[14:12];
    assign rs1         = ir_q[19:15];
    assign rs2         = ir_q[24:20];
    assign rd          = ir_q[11:7];
    assign pc_plus4    = pc_q + 32'd4;
    assign pc_plus_imm = pc_q + imm;

    imm_gen u_imm_gen (
        .instr (ir_q),
        .imm   (imm)
    );

    assign branch_taken = ((funct3 == 3'b000) && flagZ) || ((funct3 == 3'b001) && !flagZ);

    always_comb begin
        alu_op    = ALU_ADD;
        src_a     = 1'b0;
        src_b     = 1'b0;
        wb_sel    = WB_ALU;
        supported = 1'b1;
        case (opcode)
            OPC_OP:     alu_op = alu_from_funct(funct3, ir_q[30], 1'b1);
            OPC_OP_IMM: begin alu_op = alu_from_funct(funct3, ir_q[30], 1'b0); src_b = 1'b1; end
            OPC_LOAD:   begin src_b = 1'b1; wb_sel = WB_MEM; end
            OPC_STORE:  src_b = 1'b1;
            OPC_BRANCH: alu_op = ALU_SUB;
            OPC_JAL:    begin src_a = 1'b1; src_b = 1'b1; wb_sel = WB_PC; end
            OPC_LUI:    begin src_b = 1'b1; wb_sel = WB_IMM; end
            OPC_AUIPC:  begin src_a = 1'b1; src_b = 1'b1; end
            default:    supported = 1'b0;
        endcase
    end

`ifdef CONTROL_TRAP_EN
    assign decode_trap = !supported;
    assign exec_error  = flagError;
    assign trap        = (state_q == S_TRAP);
`else
    logic unused_cfg;
    assign decode_trap = 1'b0;
    assign exec_error  = 1'b0;
    assign trap        = 1'b0;
    assign unused_cfg  = flagError ^ supported;
`endif

    logic unused_address;
    assign unused_address = ^address;

    always_comb begin
        state_d = state_q;
        pc_load = 1'b0;
        pc_d    = pc_plus4;
        case (state_q)
            S_FETCH:   if (run_q && instr_valid) state_d = S_DECODE;
            S_DECODE:  state_d = decode_trap ? S_TRAP : S_EXECUTE;
            S_EXECUTE: begin
                if (exec_error) begin
                    state_d = S_TRAP;
                end else begin
                    case (opcode)
                        OPC_LOAD, OPC_STORE: state_d = S_MEMORY;
                        OPC_OP, OPC_OP_IMM, OPC_JAL, OPC_LUI, OPC_AUIPC: state_d = S_WRITEBACK;
                        OPC_BRANCH: begin
                            state_d = S_FETCH;
                            pc_load = 1'b1;
                            pc_d    = branch_taken ? pc_plus_imm : pc_plus4;
                        end
                        default: begin
                            state_d = S_FETCH;
                            pc_load = 1'b1;
                        end
                    endcase
                end
            end
            S_MEMORY: begin
                if (mem_ready) begin
                    if (opcode == OPC_LOAD) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_FETCH;
                        pc_load = 1'b1;
                    end
                end
            end
            S_WRITEBACK: begin
                state_d = S_FETCH;
                pc_load = 1'b1;
                pc_d    = (opcode == OPC_JAL) ? target_q : pc_plus4;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // run_q keeps instr_req low until the first clock edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            target_q <= '0;
            run_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (state_q == S_FETCH && run_q && instr_valid) ir_q <= instr;
            if (state_q == S_EXECUTE) target_q <= pc_plus_imm;
            if (pc_load) pc_q <= pc_d;
        end
    end

    assign instr_req  = run_q && (state_q == S_FETCH);
    assign mem_re     = (state_q == S_MEMORY) && (opcode == OPC_LOAD);
    assign mem_we     = (state_q == S_MEMORY) && (opcode == OPC_STORE);
    assign RD_WE      = (state_q == S_WRITEBACK) && (rd != 5'd0);
    assign PC         = (state_q == S_WRITEBACK && opcode == OPC_JAL) ? pc_plus4 : pc_q;
    assign SEL_OP     = alu_op;
    assign Sel_Reg_In = wb_sel;
    assign srcA_SEL   = src_a;
    assign srcB_SEL   = src_b;

endmodule

// File: tb/tb_control_multiciclo.sv
// tb/tb_control_multiciclo.sv - directed and random instruction checks of control_multiciclo against an ISA-level model
module tb_control_multiciclo;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [6:0] O_OP = 7'b0110011, O_OPI = 7'b0010011, O_LD = 7'b0000011,
                           O_ST = 7'b0100011, O_BR = 7'b1100011, O_JAL = 7'b1101111,
                           O_LUI = 7'b0110111, O_AUI = 7'b0010111;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, address, PC, imm;
    logic        instr_valid, instr_req, flagZ, flagError, mem_ready, mem_re, mem_we;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  SEL_OP;
    logic [1:0]  Sel_Reg_In;
    logic        srcA_SEL, srcB_SEL, RD_WE, trap;

    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] model_pc;

    control_multiciclo #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_req(instr_req),
        .address(address), .flagZ(flagZ), .flagError(flagError), .mem_ready(mem_ready),
        .mem_re(mem_re), .mem_we(mem_we), .PC(PC), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
        .SEL_OP(SEL_OP), .Sel_Reg_In(Sel_Reg_In), .srcA_SEL(srcA_SEL), .srcB_SEL(srcB_SEL),
        .RD_WE(RD_WE), .trap(trap)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [31:0] v, input logic [4:0] s1, input logic [2:0] f3,
                                          input logic [4:0] d, input logic [6:0] opc);
        return {v[11:0], s1, f3, d, opc};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] v, input logic [4:0] s2, input logic [4:0] s1);
        return {v[11:5], s2, s1, 3'b010, v[4:0], O_ST};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] v, input logic [4:0] s2, input logic [4:0] s1,
                                          input logic [2:0] f3);
        return {v[12], v[10:5], s2, s1, f3, v[4:1], v[11], O_BR};
    endfunction
    function automatic logic [31:0] enc_u(input logic [31:0] v, input logic [4:0] d, input logic [6:0] opc);
        return {v[31:12], d, opc};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] v, input logic [4:0] d);
        return {v[20], v[10:1], v[11], v[19:12], d, O_JAL};
    endfunction

    // ALU operation names by funct3 order: add sll slt sltu xor srl or and
    function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic b30, input bit is_reg);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        if (f3 == 3'd0 && is_reg && b30) return 4'd1;
        if (f3 == 3'd5 && b30) return 4'd7;
        return tbl[f3];
    endfunction

    task automatic run_instr(input logic [31:0] ins, input logic [31:0] immv, input bit z, input int wt);
        int          lat, exp_lat, re_n, we_n, wr_n, exp_re, exp_we, exp_wr, memcnt, clash;
        logic [31:0] exp_next, exp_wb_pc, wb_pc, ob_imm;
        logic [4:0]  wb_rd;
        logic [1:0]  wb_sel, exp_sel;
        logic [3:0]  ob_op, exp_op;
        logic        ob_a, ob_b, exp_a, exp_b;
        bit          chk_alu, chk_imm, ob_seen;
        exp_next = model_pc + 32'd4; exp_wb_pc = model_pc;
        exp_lat = 3; exp_re = 0; exp_we = 0; exp_wr = 0; exp_sel = 2'd0;
        exp_op = 4'd0; exp_a = 1'b0; exp_b = 1'b1; chk_alu = 0; chk_imm = 1;
        case (ins[6:0])
            O_OP:  begin exp_lat = 4; exp_wr = 1; exp_op = alu_ref(ins[14:12], ins[30], 1); exp_b = 1'b0; chk_alu = 1; chk_imm = 0; end
            O_OPI: begin exp_lat = 4; exp_wr = 1; exp_op = alu_ref(ins[14:12], ins[30], 0); chk_alu = 1; end
            O_LD:  begin exp_lat = 4 + wt; exp_re = wt; exp_wr = 1; exp_sel = 2'd2; chk_alu = 1; end
            O_ST:  begin exp_lat = 3 + wt; exp_we = wt; chk_alu = 1; end
            O_BR:  if ((ins[14:12] == 3'd0 && z) || (ins[14:12] == 3'd1 && !z)) exp_next = model_pc + immv;
            O_JAL: begin exp_lat = 4; exp_wr = 1; exp_sel = 2'd3; exp_wb_pc = model_pc + 32'd4; exp_next = model_pc + immv; end
            O_LUI: begin exp_lat = 4; exp_wr = 1; exp_sel = 2'd1; end
            O_AUI: begin exp_lat = 4; exp_wr = 1; exp_a = 1'b1; chk_alu = 1; end
            default: chk_imm = 0;
        endcase
        if (ins[11:7] == 5'd0) exp_wr = 0;

        check("fetch_req", instr_req, 1);
        check("fetch_pc", PC, model_pc);
        check("fetch_strobes", {mem_re, mem_we}, 0);
        instr = ins; instr_valid = 1'b1; flagZ = z; mem_ready = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0; instr = $urandom;
        lat = 1; re_n = 0; we_n = 0; wr_n = 0; memcnt = 0; clash = 0; ob_seen = 0;
        wb_pc = 'x; wb_rd = 'x; wb_sel = 'x; ob_op = 'x; ob_a = 'x; ob_b = 'x; ob_imm = 'x;
        while (!instr_req && lat < 40) begin
            re_n += int'(mem_re); we_n += int'(mem_we); wr_n += int'(RD_WE);
            if (mem_re && mem_we) clash++;
            if (!ob_seen && (mem_re || mem_we || RD_WE)) begin
                ob_seen = 1; ob_op = SEL_OP; ob_a = srcA_SEL; ob_b = srcB_SEL; ob_imm = imm;
            end
            if (RD_WE) begin wb_pc = PC; wb_rd = rd; wb_sel = Sel_Reg_In; end
            if (mem_re || mem_we) memcnt++;
            mem_ready = (mem_re || mem_we) && (memcnt >= wt);
            @(negedge clk);
            lat++;
        end
        mem_ready = 1'b0;
        check("latency", lat, exp_lat);
        check("mem_re_cycles", re_n, exp_re);
        check("mem_we_cycles", we_n, exp_we);
        check("rd_we_cycles", wr_n, exp_wr);
        check("strobe_clash", clash, 0);
        if (exp_wr > 0) begin
            check("wb_rd", wb_rd, ins[11:7]);
            check("wb_sel_reg_in", wb_sel, exp_sel);
            check("wb_pc", wb_pc, exp_wb_pc);
        end
        if (exp_wr > 0 || exp_re > 0 || exp_we > 0) begin
            if (chk_alu) begin
                check("sel_op", ob_op, exp_op);
                check("src_a", ob_a, exp_a);
                check("src_b", ob_b, exp_b);
            end
            if (chk_imm) check("imm", ob_imm, immv);
        end
        model_pc = exp_next;
    endtask

    initial begin
        int          n, kind, v;
        logic [31:0] ins, immv;
        logic [4:0]  r1, r2, rdx;
        logic [2:0]  f3;
        rst = 1'b0; instr = '0; instr_valid = 1'b0; address = '0;
        flagZ = 1'b0; flagError = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_instr_req", instr_req, 0);
        check("rst_pc", PC, RESET_PC);
        check("rst_trap", trap, 0);
        check("rst_strobes", {mem_re, mem_we, RD_WE}, 0);
        rst = 1'b1;
        model_pc = RESET_PC;
        @(negedge clk);

        run_instr(enc_i(32'd5, 5'd0, 3'd0, 5'd1, O_OPI), 32'd5, 0, 1);
        run_instr(enc_i(32'd8, 5'd1, 3'd2, 5'd2, O_LD), 32'd8, 0, 3);
        run_instr(enc_j(32'd8, 5'd0), 32'd8, 0, 1);
        run_instr(enc_b(-32'sd8, 5'd2, 5'd1, 3'd0), -32'sd8, 1, 1);
        run_instr(enc_j(32'd8, 5'd0), 32'd8, 0, 1);
        run_instr(enc_b(-32'sd8, 5'd2, 5'd1, 3'd0), -32'sd8, 0, 1);
        run_instr(enc_j(32'd12, 5'd0), 32'd12, 0, 1);
        run_instr(enc_j(32'h100, 5'd1), 32'h100, 0, 1);
        run_instr(enc_u(32'hABCDE000, 5'd5, O_LUI), 32'hABCDE000, 0, 1);
        run_instr(enc_u(32'h00012000, 5'd6, O_AUI), 32'h00012000, 0, 1);
        run_instr(enc_s(-32'sd4, 5'd3, 5'd4), -32'sd4, 0, 2);
        run_instr(enc_b(32'd16, 5'd3, 5'd4, 3'd1), 32'd16, 0, 1);
        run_instr({7'h20, 5'd3, 5'd2, 3'd0, 5'd6, O_OP}, 32'd0, 0, 1);
        run_instr(enc_i(32'd3, 5'd2, 3'd0, 5'd0, O_OPI), 32'd3, 0, 1);

`ifdef CONTROL_TRAP_EN
        instr = {25'd0, 7'h7F}; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("trap_set", trap, 1);
        check("trap_no_fetch", instr_req, 0);
        rst = 1'b0; #1;
        check("trap_cleared", trap, 0);
        @(negedge clk); rst = 1'b1; model_pc = RESET_PC;
        @(negedge clk);
`else
        run_instr({25'd0, 7'h7F}, 32'd0, 0, 1);
`endif

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 7);
            r1 = 5'($urandom_range(0, 31)); r2 = 5'($urandom_range(0, 31)); rdx = 5'($urandom_range(0, 31));
            f3 = 3'($urandom_range(0, 7));
            v = $urandom_range(0, 4095) - 2048;
            immv = v;
`ifndef CONTROL_TRAP_EN
            flagError = 1'($urandom_range(0, 1));
`endif
            case (kind)
                0: begin ins = {1'b0, 1'($urandom_range(0, 1)), 5'd0, r2, r1, f3, rdx, O_OP}; immv = 0; end
                1: ins = enc_i(immv, r1, f3, rdx, O_OPI);
                2: ins = enc_i(immv, r1, 3'd2, rdx, O_LD);
                3: ins = enc_s(immv, r2, r1);
                4: begin immv = v * 2; ins = enc_b(immv, r2, r1, 3'($urandom_range(0, 1))); end
                5: begin immv = v * 2; ins = enc_j(immv, rdx); end
                6: begin immv = $urandom & 32'hFFFFF000; ins = enc_u(immv, rdx, O_LUI); end
                default: begin immv = $urandom & 32'hFFFFF000; ins = enc_u(immv, rdx, O_AUI); end
            endcase
            run_instr(ins, immv, 1'($urandom_range(0, 1)), $urandom_range(1, 4));
        end
        flagError = 1'b0;

        check("sw_fetch_req", instr_req, 1);
        instr = enc_s(32'd0, 5'd1, 5'd2); instr_valid = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        n = 0;
        while (!mem_we && n < 10) begin @(negedge clk); n++; end
        check("sw_we_on", mem_we, 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_sw_we_drop", mem_we, 0);
        check("rst_sw_pc", PC, RESET_PC);
        check("rst_sw_req", instr_req, 0);
        check("rst_sw_rd_we", RD_WE, 0);
        @(negedge clk); rst = 1'b1; model_pc = RESET_PC;
        @(negedge clk);

        run_instr(enc_j(-32'sd4, 5'd0), -32'sd4, 0, 1);
        run_instr(enc_i(32'd1, 5'd1, 3'd0, 5'd1, O_OPI), 32'd1, 0, 1);
        check("wrap_fetch_req", instr_req, 1);
        check("wrap_pc", PC, model_pc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/control_multiciclo.md
CONTROL_MULTICICLO -- requirements
Module: control_multiciclo

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have ports, one per line:
 clk  in  1  single clock, all state on rising edge
 rst  in  1  asynchronous, active-low reset
 instr  in  32  instruction word from instruction memory
 instr_valid  in  1  instr is valid this cycle
 instr_req  out  1  fetch request at address PC
 address  in  32  ALU result fed back from datapath
 flagZ  in  1  ALU zero flag
 flagError  in  1  ALU error flag
 mem_ready  in  1  data memory completed access
 mem_re, mem_we  out  1 each  data memory read/write strobes
 PC, imm  out  32 each  datapath program counter and sign-extended immediate
 rs1, rs2, rd  out  5 each  register addresses
 SEL_OP  out  4  ALU operation
 Sel_Reg_In  out  2  writeback source: 0 ALU, 1 imm, 2 Memoria, 3 PC
 srcA_SEL, srcB_SEL  out  1 each  A: 0 RS1 / 1 PC; B: 0 RS2 / 1 imm
 RD_WE  out  1  register file write enable
 trap  out  1  sticky trap indicator

Function
REQ-003 SHALL implement FSM states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
REQ-004 FETCH SHALL hold instr_req=1 until instr_valid=1, then latch instr into IR and go to DECODE; wait is unbounded.
REQ-005 DECODE SHALL last exactly one cycle and drive rs1/rs2/rd/imm from IR; decoded fields SHALL be held stable until the next FETCH.
REQ-006 Supported opcodes: OP, OP-IMM, LOAD (LW), STORE (SW), BRANCH (BEQ, BNE), JAL, LUI, AUIPC.
REQ-007 EXECUTE SHALL last one cycle; SEL_OP, srcA_SEL and srcB_SEL SHALL be valid in EXECUTE, MEMORY and WRITEBACK.
REQ-008 LW/SW SHALL use SEL_OP=ADD, srcA=RS1, srcB=imm; MEMORY SHALL hold mem_re (LW) or mem_we (SW) until mem_ready=1.
REQ-009 LW SHALL then go to WRITEBACK with Sel_Reg_In=2; SW SHALL return to FETCH with no writeback.
REQ-010 BEQ/BNE SHALL use SEL_OP=SUB with RS1, RS2; taken if flagZ (BEQ) or !flagZ (BNE); target SHALL be PC+imm from an internal adder; branches SHALL not write back.
REQ-011 JAL SHALL compute PC+imm in EXECUTE, latch it as next PC, and write PC+4 to rd in WRITEBACK with Sel_Reg_In=3 (PC output = PC+4 in that state only).
REQ-012 LUI SHALL write back with Sel_Reg_In=1; AUIPC SHALL use srcA=PC, srcB=imm, ADD, Sel_Reg_In=0.
REQ-013 RD_WE SHALL pulse for exactly one cycle in WRITEBACK; it SHALL be suppressed when rd=0.
REQ-014 PC SHALL update only on the WRITEBACK->FETCH or EXECUTE/MEMORY->FETCH transition: target if jump/taken, else PC+4 with 32-bit wrap (32'hFFFF_FFFC -> 0).
REQ-015 Latency from fetch accept: ALU/LUI/AUIPC/JAL 4 cycles, branch 3, LW/SW 4 + memory wait (SW 3 + wait).
REQ-016 instr_req, mem_re and mem_we SHALL never be asserted simultaneously.

Reset
REQ-017 rst=0 SHALL asynchronously force state=FETCH, PC=RESET_PC, IR=0, trap=0 and all strobes (instr_req, mem_re, mem_we, RD_WE) to 0.
REQ-018 Reset asserted during MEMORY SHALL drop mem_re/mem_we immediately with no writeback.
REQ-019 After rst deasserts, instr_req SHALL assert on the first rising edge.

Configuration
REQ-020 Macro CONTROL_TRAP_EN: when defined, an unsupported opcode in DECODE, or flagError=1 in EXECUTE, SHALL enter TRAP, set trap=1 and hold there until reset. When undefined, unsupported opcodes SHALL execute as NOPs (PC+4), flagError SHALL be ignored and trap SHALL be tied to 0.

Structure
REQ-021 A shared package SHALL hold the state enum, opcode constants, SEL_OP encodings (ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9) and Sel_Reg_In encodings.
REQ-022 Immediate generation SHALL be the sub-module imm_gen (combinational, I/S/B/U/J formats).

Verification
REQ-023 Reset then instr_valid=1 with ADDI x1,x0,5 -> instr_req at PC=0, RD_WE one cycle with rd=1, srcB=1, Sel_Reg_In=0, next PC=4.
REQ-024 LW x2,8(x1) with mem_ready delayed 3 cycles -> mem_re held 3 cycles, then RD_WE with Sel_Reg_In=2.
REQ-025 BEQ at PC=0x10, imm=-8, flagZ=1 -> next PC=0x08, RD_WE never asserted; with flagZ=0 -> next PC=0x14.
REQ-026 JAL x1,+0x100 at PC=0x20 -> WRITEBACK with PC output 0x24 and Sel_Reg_In=3, then fetch at 0x120.
REQ-027 rst pulled low mid-MEMORY of SW -> mem_we drops asynchronously, PC=RESET_PC, fetch restarts.
REQ-028 Opcode 7'b1111111 -> trap=1, FSM stuck in TRAP (CONTROL_TRAP_EN defined); treated as NOP with PC+4 (undefined).
